// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multi-cycle RV32I fetch/decode/execute controller that owns the PC.
// It traps into HALT with a cause code on an illegal opcode, a bus timeout or a misaligned target.
module ctrl_unit_mc #(
    parameter int          ADDR_WIDTH  = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BUS_TIMEOUT = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    output logic [ADDR_WIDTH-1:0] Wb_addr,
    output logic                  Wb_cs,
    output logic                  Wb_we,
    output logic [31:0]           Wb_wdata,
    input  logic [31:0]           Wb_rdata,
    input  logic                  Wb_ack,
    output logic [4:0]            Rs1_id,
    output logic [4:0]            Rs2_id,
    input  logic [31:0]           Rs1_data,
    input  logic [31:0]           Rs2_data,
    output logic [4:0]            Rd_id,
    output logic [31:0]           Rd_data,
    output logic                  Rd_write,
    output logic [3:0]            Alu_control,
    output logic                  Alu_enable,
    output logic [11:0]           Imm_data,
    output logic                  Imm_enable,
    output logic [ADDR_WIDTH-1:0] Pc,
    output logic                  Halted,
    output logic [1:0]            Trap_cause
);
    localparam int            TW       = $clog2(BUS_TIMEOUT);
    localparam logic [TW-1:0] TO_LIMIT = TW'(BUS_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_LOAD, S_EX_STORE,
        S_EX_JAL, S_EX_JALR, S_EX_BRANCH, S_EX_LUI, S_HALT
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_pc, w_pc_next;
    logic [31:0]           r_instr;
    logic [TW-1:0]         r_tcount;
    logic [1:0]            r_cause, w_cause_next;
    logic                  w_load_instr, w_rd_we, w_cs, w_ls_mis, w_timeout, w_br_taken;
    logic [2:0]            w_funct3;
    logic [31:0]           w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_ls_imm;
    logic [ADDR_WIDTH-1:0] w_pc4, w_ls_addr, w_jal_tgt, w_jalr_sum, w_jalr_tgt, w_br_tgt;

    assign w_funct3   = r_instr[14:12];
    assign w_imm_i    = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s    = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b    = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
    assign w_imm_j    = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
    assign w_ls_imm   = (r_state == S_EX_STORE) ? w_imm_s : w_imm_i;

    // All address arithmetic wraps at ADDR_WIDTH bits.
    assign w_pc4      = r_pc + ADDR_WIDTH'(4);
    assign w_ls_addr  = Rs1_data[ADDR_WIDTH-1:0] + w_ls_imm[ADDR_WIDTH-1:0];
    assign w_jal_tgt  = r_pc + w_imm_j[ADDR_WIDTH-1:0];
    assign w_jalr_sum = Rs1_data[ADDR_WIDTH-1:0] + w_imm_i[ADDR_WIDTH-1:0];
    assign w_jalr_tgt = {w_jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    assign w_br_tgt   = r_pc + w_imm_b[ADDR_WIDTH-1:0];
    assign w_br_taken = (Rs1_data == Rs2_data) ^ w_funct3[0];
    assign w_ls_mis   = (w_ls_addr[1:0] != 2'b00);

    // A misaligned load/store never raises a bus request.
    assign w_cs      = (r_state == S_FETCH) ||
                       (((r_state == S_EX_LOAD) || (r_state == S_EX_STORE)) && !w_ls_mis);
    assign w_timeout = w_cs && !Wb_ack && (r_tcount == TO_LIMIT);

    assign Wb_cs      = w_cs;
    assign Rd_write   = w_rd_we && (Rd_id != 5'd0);
    assign Pc         = r_pc;
    assign Halted     = (r_state == S_HALT);
    assign Trap_cause = r_cause;

    // State, PC, instruction, trap cause and bus-watchdog registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC[ADDR_WIDTH-1:0];
            r_instr  <= 32'd0;
            r_tcount <= {TW{1'b0}};
            r_cause  <= 2'd0;
        end else begin
            r_state  <= w_next;
            r_pc     <= w_pc_next;
            r_cause  <= w_cause_next;
            r_tcount <= (w_cs && !Wb_ack && (w_next == r_state)) ? r_tcount + TW'(1) : {TW{1'b0}};
            if (w_load_instr) begin
                r_instr <= Wb_rdata;
            end
        end
    end

    // Next-state, next-PC and per-state datapath control.
    always_comb begin
        w_next       = r_state;
        w_pc_next    = r_pc;
        w_cause_next = r_cause;
        w_load_instr = 1'b0;
        w_rd_we      = 1'b0;
        Wb_addr      = {ADDR_WIDTH{1'b0}};
        Wb_we        = 1'b0;
        Wb_wdata     = 32'd0;
        Rs1_id       = 5'd0;
        Rs2_id       = 5'd0;
        Rd_id        = 5'd0;
        Rd_data      = 32'd0;
        Alu_control  = 4'd0;
        Alu_enable   = 1'b0;
        Imm_data     = 12'd0;
        Imm_enable   = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                Wb_addr = r_pc;
                if (Wb_ack) begin
                    w_load_instr = 1'b1;
                    w_next       = S_DECODE;
                end else if (w_timeout) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd2;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (r_instr[6:0])
                    7'b0110011: w_next = S_EX_R;
                    7'b0010011: w_next = S_EX_I;
                    7'b0000011: w_next = S_EX_LOAD;
                    7'b0100011: w_next = S_EX_STORE;
                    7'b1101111: w_next = S_EX_JAL;
                    7'b1100111: w_next = S_EX_JALR;
                    7'b1100011: w_next = S_EX_BRANCH;
                    7'b0110111: w_next = S_EX_LUI;
                    default: begin
                        w_next       = S_HALT;
                        w_cause_next = 2'd1;
                    end
                endcase
            end
            S_EX_R, S_EX_I: begin
                Rs1_id     = r_instr[19:15];
                Rd_id      = r_instr[11:7];
                Alu_enable = 1'b1;
                w_rd_we    = 1'b1;
                w_pc_next  = w_pc4;
                w_next     = S_FETCH;
                if (r_state == S_EX_R) begin
                    Rs2_id      = r_instr[24:20];
                    Alu_control = {r_instr[30], w_funct3};
                end else begin
                    // Only shifts (funct3 101) use bit 30 to pick SRAI over SRLI.
                    Imm_enable  = 1'b1;
                    Imm_data    = r_instr[31:20];
                    Alu_control = {(w_funct3 == 3'b101) & r_instr[30], w_funct3};
                end
            end
            S_EX_LOAD, S_EX_STORE: begin
                Rs1_id = r_instr[19:15];
                if (r_state == S_EX_LOAD) begin
                    Rd_id = r_instr[11:7];
                end else begin
                    Rs2_id = r_instr[24:20];
                end
                if (w_ls_mis) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd3;
                end else begin
                    Wb_addr = w_ls_addr;
                    if (r_state == S_EX_LOAD) begin
                        Rd_data = Wb_rdata;
                        w_rd_we = Wb_ack;
                    end else begin
                        Wb_we    = 1'b1;
                        Wb_wdata = Rs2_data;
                    end
                    if (Wb_ack) begin
                        w_pc_next = w_pc4;
                        w_next    = S_FETCH;
                    end else if (w_timeout) begin
                        w_next       = S_HALT;
                        w_cause_next = 2'd2;
                    end else begin
                        w_next = r_state;
                    end
                end
            end
            S_EX_JAL, S_EX_JALR: begin
                Rd_id = r_instr[11:7];
                if (r_state == S_EX_JALR) begin
                    Rs1_id = r_instr[19:15];
                end else begin
                    Rs1_id = 5'd0;
                end
                if (((r_state == S_EX_JAL) ? w_jal_tgt[1:0] : w_jalr_tgt[1:0]) != 2'b00) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd3;
                end else begin
                    Rd_data   = 32'(w_pc4);
                    w_rd_we   = 1'b1;
                    w_pc_next = (r_state == S_EX_JAL) ? w_jal_tgt : w_jalr_tgt;
                    w_next    = S_FETCH;
                end
            end
            S_EX_BRANCH: begin
                Rs1_id = r_instr[19:15];
                Rs2_id = r_instr[24:20];
                if (w_funct3[2:1] != 2'b00) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd1;
                end else if (w_br_taken && (w_br_tgt[1:0] != 2'b00)) begin
                    w_next       = S_HALT;
                    w_cause_next = 2'd3;
                end else begin
                    w_pc_next = w_br_taken ? w_br_tgt : w_pc4;
                    w_next    = S_FETCH;
                end
            end
            S_EX_LUI: begin
                Rd_id     = r_instr[11:7];
                Rd_data   = {r_instr[31:12], 12'd0};
                w_rd_we   = 1'b1;
                w_pc_next = w_pc4;
                w_next    = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end
endmodule
